wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued writeback entries (power of 2, 2..16).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports alu_valid_i  input  1, alu_rd_i  input  5, alu_data_i  input  32: ALU writeback request.
REQ-005 SHALL have ports ld_valid_i  input  1, ld_rd_i  input  5, ld_data_i  input  32: load-unit writeback request.
REQ-006 SHALL have ports alu_ready_o  output  1 and ld_ready_o  output  1: request accepted on an edge where valid and ready are both high.
REQ-007 SHALL have port stall_i  input  1  blocks issue of writes to the register file.
REQ-008 SHALL have ports regwren_o  output  1, rd_o  output  5, datawb_o  output  32: registered write port driving the register file.
REQ-009 SHALL have port count_o  output  $clog2(DEPTH)+1  number of queued entries, excluding the output stage.
REQ-010 SHALL have ports query_rs_i  input  5 and pending_o  output  1: hazard lookup.
REQ-011 SHALL have ports fwd_valid_o  output  1 and fwd_data_o  output  32: forwarded data for query_rs_i.

Function
REQ-012 SHALL accept at most one request per cycle; load has priority over ALU when both are valid.
REQ-013 SHALL drive ld_ready_o = !full and alu_ready_o = !full && !ld_valid_i, combinationally; full means count == DEPTH.
REQ-014 SHALL accept requests with rd == 0 but never store or issue them, leaving count unchanged.
REQ-015 SHALL store accepted entries in FIFO order in a circular buffer; read and write pointers wrap modulo DEPTH.
REQ-016 SHALL, on each edge with !stall_i and count > 0, pop the head into rd_o/datawb_o and set regwren_o = 1.
REQ-017 SHALL set regwren_o = 0 on any edge where stall_i = 1 or count == 0; rd_o/datawb_o SHALL hold their previous values.
REQ-018 SHALL have a latency of one edge: a request accepted at edge N into an empty, unstalled queue appears on regwren_o after edge N+1.
REQ-019 SHALL update count by +1 on push-only, -1 on pop-only, and 0 when push and pop occur on the same edge.
REQ-020 SHALL, when full, still pop on an unstalled edge; ready SHALL NOT reflect that same-cycle pop.
REQ-021 SHALL assert pending_o combinationally when query_rs_i != 0 and it matches any queued entry's rd or the output stage (regwren_o = 1 and rd_o).
REQ-022 SHALL drive pending_o = 0 when query_rs_i == 0.

Reset
REQ-023 SHALL, while reset_i is high, asynchronously clear both pointers, set count_o = 0 and regwren_o = 0, and set rd_o = 0 and datawb_o = 0.
REQ-024 SHALL discard all queued entries on reset mid-operation; no write SHALL issue after reset is released until a new request is accepted.

Configuration
REQ-025 SHALL define WB_BYPASS_EN as the forwarding macro.
REQ-026 SHALL, with WB_BYPASS_EN defined, drive fwd_valid_o = pending_o and fwd_data_o = the data of the youngest matching entry. Age order is queue tail down to head, then the output stage.
REQ-027 SHALL, without WB_BYPASS_EN, tie fwd_valid_o = 0 and fwd_data_o = 0; pending_o is unaffected.

Verification
REQ-028 SHALL cover basic issue: ALU valid, rd = 5, data = 0x1234 into an empty queue -> regwren_o = 1, rd_o = 5, datawb_o = 0x1234 one edge after acceptance, then regwren_o = 0.
REQ-029 SHALL cover priority: ALU (rd = 3, 0xA) and load (rd = 4, 0xB) valid together -> load accepted first, alu_ready_o = 0, then ALU accepted next cycle; issue order is x4 then x3.
REQ-030 SHALL cover full/stall: stall_i = 1 with 4 pushes (DEPTH = 4) -> count_o = 4, both ready = 0; drop stall -> writes issue on 4 consecutive edges in push order.
REQ-031 SHALL cover x0 and wrap: push rd = 0 -> count_o unchanged and no write; then 10 pushes/pops through DEPTH = 4 -> all data is issued in order across pointer wrap.
REQ-032 SHALL cover forwarding: queue x7 = 0x1, then x7 = 0x2, query_rs_i = 7 -> pending_o = 1; with WB_BYPASS_EN, fwd_data_o = 0x2; without it, fwd_valid_o = 0.
REQ-033 SHALL cover reset mid-operation: assert reset_i with 3 entries queued -> count_o = 0 and regwren_o = 0 immediately (asynchronous), and no stale write after release.

Source files
------------

// File: rtl/wb_queue.sv
// ============================================================================
//  Module   : wb_queue
//  Brief    : Writeback queue merging ALU and load results into one register
//             file write port, with hazard lookup and optional forwarding
//             (enabled by defining WB_BYPASS_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic [31:0]                alu_data_i,
    input  logic                       ld_valid_i,
    input  logic [4:0]                 ld_rd_i,
    input  logic [31:0]                ld_data_i,
    output logic                       alu_ready_o,
    output logic                       ld_ready_o,
    input  logic                       stall_i,
    output logic                       regwren_o,
    output logic [4:0]                 rd_o,
    output logic [31:0]                datawb_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  logic [4:0]                 query_rs_i,
    output logic                       pending_o,
    output logic                       fwd_valid_o,
    output logic [31:0]                fwd_data_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          regwren_q, regwren_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   data_q, data_d;

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [4:0]    rd_mem_d   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];

    logic          full;
    logic          ld_acc;
    logic          alu_acc;
    logic [4:0]    push_rd;
    logic [31:0]   push_data;
    logic          push;
    logic          pop;
    logic [DEPTH-1:0] entry_match;
    logic          any_match;

    assign full        = (count_q == C_FULL);
    assign ld_ready_o  = !full;
    assign alu_ready_o = !full && !ld_valid_i;

    assign ld_acc    = ld_valid_i && ld_ready_o;
    assign alu_acc   = alu_valid_i && alu_ready_o;
    assign push_rd   = ld_acc ? ld_rd_i   : alu_rd_i;
    assign push_data = ld_acc ? ld_data_i : alu_data_i;
    // Writes to x0 are handshaken but silently dropped.
    assign push      = (ld_acc || alu_acc) && (push_rd != 5'd0);
    assign pop       = !stall_i && (count_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        regwren_d  = pop;
        rd_d       = rd_q;
        data_d     = data_q;

        if (push) begin
            rd_mem_d[wr_ptr_q]   = push_rd;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_d     = rd_mem_q[rd_ptr_q];
            data_d   = data_mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            regwren_q <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            regwren_q <= regwren_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    // Storage needs no reset: only slots below count_q are ever observed.
    always_ff @(posedge clk_i) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign regwren_o = regwren_q;
    assign rd_o      = rd_q;
    assign datawb_o  = data_q;
    assign count_o   = count_q;

    // Slot k of entry_match is the k-th oldest queued entry (0 = head).
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [PW-1:0] idx;
        assign idx            = rd_ptr_q + PW'(k);
        assign entry_match[k] = (CW'(k) < count_q) && (rd_mem_q[idx] == query_rs_i);
    end

    assign any_match = (|entry_match) || (regwren_q && (rd_q == query_rs_i));
    assign pending_o = (query_rs_i != 5'd0) && any_match;

`ifdef WB_BYPASS_EN
    logic [31:0] hit_data;

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        hit_data = '0;
        if (regwren_q && (rd_q == query_rs_i)) begin
            hit_data = data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (entry_match[k]) begin
                hit_data = data_mem_q[rd_ptr_q + PW'(k)];
            end
        end
    end

    assign fwd_valid_o = pending_o;
    assign fwd_data_o  = hit_data;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_data_o  = 32'd0;
`endif

endmodule

`default_nettype wire
